// File: rtl/multicycle_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mc_pkg
//  Brief    : Shared encodings for the multi-cycle accumulator processor:
//             opcodes, ALU function selects and controller state codes.
//  Revision : 1.0 - initial release
// ============================================================================
package mc_pkg;

    // Instruction opcodes, IR[15:13]
    localparam logic [2:0] OP_LDA = 3'd0;
    localparam logic [2:0] OP_STA = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_INC = 3'd5;
    localparam logic [2:0] OP_JMP = 3'd6;
    localparam logic [2:0] OP_JZ  = 3'd7;

    // ALU function selects, shared with the datapath ALU
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_PASS = 2'b11;

    // Controller state codes (also exported on the debug state output)
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEM_RD  = 4'd2,
        LOAD_WB = 4'd3,
        ALU_EX  = 4'd4,
        INC_EX  = 4'd5,
        STORE   = 4'd6,
        JUMP    = 4'd7,
        JZ_EX   = 4'd8
    } state_t;

    // ALU function for the two-operand arithmetic/logic instructions
    function automatic logic [1:0] alu_func_of(input logic [2:0] op);
        logic [1:0] f;
        f = ALU_ADD;
        if (op == OP_SUB) f = ALU_SUB;
        if (op == OP_AND) f = ALU_AND;
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_controller_if.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_controller_if
//  Brief    : Controller <-> datapath bundle: opcode from the IR, every
//             datapath control strobe, plus debug state and instr_done.
//  Revision : 1.0 - initial release
// ============================================================================
interface multicycle_controller_if;

    logic [2:0] opcode;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       memRead;
    logic       memWrite;
    logic       IRWrite;
    logic       memToAcc;
    logic       accWrite;
    logic       ALUSrcA;
    logic       ALUSrcB;
    logic       PCSrc;
    logic [1:0] ALUFunc;
    logic [3:0] state;
    logic       instr_done;

    // Controller side
    modport master (
        input  opcode,
        output PCWrite, PCWriteCond, IorD, memRead, memWrite, IRWrite,
               memToAcc, accWrite, ALUSrcA, ALUSrcB, PCSrc, ALUFunc,
               state, instr_done
    );

    // Datapath side
    modport slave (
        output opcode,
        input  PCWrite, PCWriteCond, IorD, memRead, memWrite, IRWrite,
               memToAcc, accWrite, ALUSrcA, ALUSrcB, PCSrc, ALUFunc,
               state, instr_done
    );

endinterface
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_controller
//  Brief    : Moore control FSM for the 16-bit multi-cycle accumulator
//             datapath (fetch, decode, operand read, execute, write-back,
//             store, jump). Outputs depend on registered state only; reset
//             forces every read/write enable low combinationally.
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_controller
    import mc_pkg::*;
(
    input  wire logic                    clk,
    input  wire logic                    rst,
    multicycle_controller_if.master      mc_bus
);

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] r_alu_func;

    logic       w_pc_write;
    logic       w_pc_write_cond;
    logic       w_iord;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_mem_to_acc;
    logic       w_acc_write;
    logic       w_alu_src_a;
    logic       w_alu_src_b;
    logic       w_pc_src;
    logic [1:0] w_alu_func;
    logic       w_instr_done;

    // State register; reset returns to FETCH from any state
    always_ff @(posedge clk) begin
        if (rst) r_state <= FETCH;
        else     r_state <= w_next_state;
    end

    // ALU function captured from the opcode in MEM_RD so that ALU_EX
    // outputs depend on registered state only
    always_ff @(posedge clk) begin
        if (rst)                    r_alu_func <= ALU_ADD;
        else if (r_state == MEM_RD) r_alu_func <= alu_func_of(mc_bus.opcode);
    end

    // Next-state decode; unreachable codes fall back to FETCH
    always_comb begin
        w_next_state = FETCH;
        case (r_state)
            FETCH:   w_next_state = DECODE;
            DECODE: begin
                case (mc_bus.opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_AND: w_next_state = MEM_RD;
                    OP_STA:                         w_next_state = STORE;
                    OP_INC:                         w_next_state = INC_EX;
                    OP_JMP:                         w_next_state = JUMP;
                    OP_JZ:                          w_next_state = JZ_EX;
                    default:                        w_next_state = FETCH;
                endcase
            end
            MEM_RD:  w_next_state = (mc_bus.opcode == OP_LDA) ? LOAD_WB : ALU_EX;
            default: w_next_state = FETCH;
        endcase
    end

    // Per-state control decode; anything not set stays 0
    always_comb begin
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_iord          = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_mem_to_acc    = 1'b0;
        w_acc_write     = 1'b0;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = 1'b0;
        w_pc_src        = 1'b0;
        w_alu_func      = ALU_ADD;
        w_instr_done    = 1'b0;
        case (r_state)
            FETCH: begin
                w_mem_read  = 1'b1;
                w_ir_write  = 1'b1;
                w_alu_src_b = 1'b1;
                w_pc_write  = 1'b1;
            end
            MEM_RD: begin
                w_iord     = 1'b1;
                w_mem_read = 1'b1;
            end
            LOAD_WB: begin
                w_mem_to_acc = 1'b1;
                w_acc_write  = 1'b1;
                w_instr_done = 1'b1;
            end
            ALU_EX: begin
                w_alu_src_a  = 1'b1;
                w_acc_write  = 1'b1;
                w_alu_func   = r_alu_func;
                w_instr_done = 1'b1;
            end
            INC_EX: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = 1'b1;
                w_acc_write  = 1'b1;
                w_instr_done = 1'b1;
            end
            STORE: begin
                w_iord       = 1'b1;
                w_mem_write  = 1'b1;
                w_instr_done = 1'b1;
            end
            JUMP: begin
                w_pc_src     = 1'b1;
                w_pc_write   = 1'b1;
                w_instr_done = 1'b1;
            end
            JZ_EX: begin
                w_alu_src_a     = 1'b1;
                w_alu_func      = ALU_PASS;
                w_pc_src        = 1'b1;
                w_pc_write_cond = 1'b1;
                w_instr_done    = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables and instr_done are suppressed while reset is held so an
    // in-flight write cannot commit on the resetting edge
    assign mc_bus.PCWrite     = w_pc_write      & ~rst;
    assign mc_bus.PCWriteCond = w_pc_write_cond & ~rst;
    assign mc_bus.memRead     = w_mem_read      & ~rst;
    assign mc_bus.memWrite    = w_mem_write     & ~rst;
    assign mc_bus.IRWrite     = w_ir_write      & ~rst;
    assign mc_bus.accWrite    = w_acc_write     & ~rst;
    assign mc_bus.instr_done  = w_instr_done    & ~rst;
    assign mc_bus.IorD        = w_iord;
    assign mc_bus.memToAcc    = w_mem_to_acc;
    assign mc_bus.ALUSrcA     = w_alu_src_a;
    assign mc_bus.ALUSrcB     = w_alu_src_b;
    assign mc_bus.PCSrc       = w_pc_src;
    assign mc_bus.ALUFunc     = w_alu_func;
    assign mc_bus.state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_controller
//  Brief    : Bench for multicycle_controller. A small datapath harness
//             executes the controller's strobes; an instruction-level model
//             predicts acc/PC/memory and the state sequence per instruction.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk    (clk),
        .rst    (rst),
        .mc_bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- datapath harness ----------------
    logic [15:0] dp_mem [0:255];
    logic [15:0] dp_acc, dp_ir, dp_mdr;
    logic [12:0] dp_pc;
    logic        ld_clr = 1'b0, ld_mem_en = 1'b0, ld_acc_en = 1'b0, ld_pc_en = 1'b0;
    logic [7:0]  ld_addr = 8'd0;
    logic [15:0] ld_data = 16'd0;
    logic [12:0] w_addr;
    logic [15:0] w_a, w_b, w_alu;

    assign bus.opcode = dp_ir[15:13];

    always_comb begin
        w_addr = bus.IorD ? dp_ir[12:0] : dp_pc;
        w_a    = bus.ALUSrcA ? dp_acc : {3'b000, dp_pc};
        w_b    = bus.ALUSrcB ? 16'd1 : dp_mdr;
        case (bus.ALUFunc)
            2'b00:   w_alu = w_a + w_b;
            2'b01:   w_alu = w_a - w_b;
            2'b10:   w_alu = w_a & w_b;
            default: w_alu = w_a;
        endcase
    end

    always @(posedge clk) begin
        if (ld_clr) begin
            for (int i = 0; i < 256; i++) dp_mem[i] <= 16'h0000;
        end else if (ld_mem_en) dp_mem[ld_addr] <= ld_data;
        else if (bus.memWrite)  dp_mem[w_addr[7:0]] <= dp_acc;
        if (ld_acc_en)         dp_acc <= ld_data;
        else if (bus.accWrite) dp_acc <= bus.memToAcc ? dp_mdr : w_alu;
        if (ld_pc_en) dp_pc <= ld_data[12:0];
        else if (bus.PCWrite || (bus.PCWriteCond && (w_alu == 16'h0000)))
            dp_pc <= bus.PCSrc ? dp_ir[12:0] : w_alu[12:0];
        if (bus.IRWrite) dp_ir  <= dp_mem[w_addr[7:0]];
        if (bus.memRead) dp_mdr <= dp_mem[w_addr[7:0]];
    end

    logic [12:0] w_ctrl;
    logic [5:0]  w_enables;
    assign w_ctrl = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.memRead, bus.memWrite,
                     bus.IRWrite, bus.memToAcc, bus.accWrite, bus.ALUSrcA, bus.ALUSrcB,
                     bus.PCSrc, bus.ALUFunc};
    assign w_enables = {bus.PCWrite, bus.PCWriteCond, bus.IRWrite, bus.accWrite,
                        bus.memWrite, bus.memRead};

    // ---------------- instruction-level reference ----------------
    logic [15:0] ref_mem [0:255];
    logic [15:0] ref_acc;
    logic [12:0] ref_pc;

    function automatic logic [15:0] ins(input logic [2:0] op, input logic [12:0] a);
        return {op, a};
    endfunction

    // Expected state code in cycle c of an instruction with opcode op
    function automatic int exp_state(input logic [2:0] op, input int c);
        if (c == 0) return 0;
        if (c == 1) return 1;
        case (op)
            3'd0:             return (c == 2) ? 2 : 3;
            3'd2, 3'd3, 3'd4: return (c == 2) ? 2 : 4;
            3'd1:             return 6;
            3'd5:             return 5;
            3'd6:             return 7;
            default:          return 8;
        endcase
    endfunction

    // Expected control vector for a state code, from the per-state output table
    function automatic logic [12:0] exp_ctrl(input int st, input logic [2:0] op);
        logic pcw, pcc, iord, mr, mw, irw, m2a, aw, sa, sb, ps;
        logic [1:0] f;
        {pcw, pcc, iord, mr, mw, irw, m2a, aw, sa, sb, ps} = '0;
        f = 2'b00;
        case (st)
            0: begin mr = 1; irw = 1; sb = 1; pcw = 1; end
            2: begin iord = 1; mr = 1; end
            3: begin m2a = 1; aw = 1; end
            4: begin sa = 1; aw = 1; f = (op == 3'd3) ? 2'b01 : (op == 3'd4) ? 2'b10 : 2'b00; end
            5: begin sa = 1; sb = 1; aw = 1; end
            6: begin iord = 1; mw = 1; end
            7: begin ps = 1; pcw = 1; end
            8: begin sa = 1; f = 2'b11; ps = 1; pcc = 1; end
            default: ;
        endcase
        return {pcw, pcc, iord, mr, mw, irw, m2a, aw, sa, sb, ps, f};
    endfunction

    // ---------------- load helpers (used while reset is held) ----------------
    task automatic enter_reset();
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic ld_clear();
        ld_clr = 1'b1;
        @(negedge clk);
        ld_clr = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
    endtask

    task automatic ld_word(input logic [7:0] a, input logic [15:0] d);
        ld_mem_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_mem_en = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic ld_acc(input logic [15:0] d);
        ld_acc_en = 1'b1; ld_data = d;
        @(negedge clk);
        ld_acc_en = 1'b0;
        ref_acc = d;
    endtask

    task automatic ld_pc(input logic [12:0] p);
        ld_pc_en = 1'b1; ld_data = {3'b000, p};
        @(negedge clk);
        ld_pc_en = 1'b0;
        ref_pc = p;
    endtask

    // Run n instructions from the current FETCH cycle, checking every cycle
    // and the architectural state after each instruction
    task automatic run_instrs(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            logic [15:0] iw;
            logic [2:0]  op;
            logic [7:0]  a;
            int          ncyc;
            iw   = ref_mem[ref_pc[7:0]];
            op   = iw[15:13];
            a    = iw[7:0];
            ncyc = (op == 3'd0 || op == 3'd2 || op == 3'd3 || op == 3'd4) ? 4 : 3;
            ref_pc = ref_pc + 13'd1;
            case (op)
                3'd0: ref_acc = ref_mem[a];
                3'd1: ref_mem[a] = ref_acc;
                3'd2: ref_acc = ref_acc + ref_mem[a];
                3'd3: ref_acc = ref_acc - ref_mem[a];
                3'd4: ref_acc = ref_acc & ref_mem[a];
                3'd5: ref_acc = ref_acc + 16'd1;
                3'd6: ref_pc = iw[12:0];
                default: if (ref_acc == 16'h0000) ref_pc = iw[12:0];
            endcase
            for (int c = 0; c < ncyc; c++) begin
                int st;
                st = exp_state(op, c);
                #1;
                checks++;
                if (bus.state !== 4'(st)) begin
                    errors++;
                    $display("FAIL %s state i%0d c%0d got %0d want %0d", tag, k, c, bus.state, st);
                end
                checks++;
                if (w_ctrl !== exp_ctrl(st, op)) begin
                    errors++;
                    $display("FAIL %s ctrl i%0d c%0d got %h want %h", tag, k, c, w_ctrl, exp_ctrl(st, op));
                end
                checks++;
                if (bus.instr_done !== (c == ncyc - 1)) begin
                    errors++;
                    $display("FAIL %s instr_done i%0d c%0d got %b want %b", tag, k, c,
                             bus.instr_done, (c == ncyc - 1));
                end
                @(negedge clk);
            end
            #1;
            checks++;
            if (dp_acc !== ref_acc) begin
                errors++;
                $display("FAIL %s acc i%0d got %h want %h", tag, k, dp_acc, ref_acc);
            end
            checks++;
            if (dp_pc !== ref_pc) begin
                errors++;
                $display("FAIL %s pc i%0d got %h want %h", tag, k, dp_pc, ref_pc);
            end
            if (op == 3'd1) begin
                checks++;
                if (dp_mem[a] !== ref_mem[a]) begin
                    errors++;
                    $display("FAIL %s mem[%0d] got %h want %h", tag, a, dp_mem[a], ref_mem[a]);
                end
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if (w_enables !== 6'b0 || bus.instr_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_pre enables got %b/%b want 000000/0", w_enables, bus.instr_done);
        end
        repeat (2) begin
            @(negedge clk);
            #1;
            checks++;
            if (bus.state !== 4'd0) begin
                errors++;
                $display("FAIL reset state got %0d want 0", bus.state);
            end
            checks++;
            if (w_enables !== 6'b0 || bus.instr_done !== 1'b0) begin
                errors++;
                $display("FAIL reset enables got %b/%b want 000000/0", w_enables, bus.instr_done);
            end
        end
        ld_clear();
        ld_word(8'd0, ins(3'd5, 13'd0));
        ld_acc(16'h0000);
        ld_pc(13'd0);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.state !== 4'd0 || bus.memRead !== 1'b1 || bus.IRWrite !== 1'b1 || bus.PCWrite !== 1'b1) begin
            errors++;
            $display("FAIL release_fetch got st=%0d mr=%b irw=%b pcw=%b want 0 1 1 1",
                     bus.state, bus.memRead, bus.IRWrite, bus.PCWrite);
        end
        checks++;
        if (w_ctrl !== exp_ctrl(0, 3'd0)) begin
            errors++;
            $display("FAIL release_ctrl got %h want %h", w_ctrl, exp_ctrl(0, 3'd0));
        end
        @(negedge clk);
    endtask

    task automatic test_lda_add();
        enter_reset();
        ld_clear();
        ld_word(8'd0, ins(3'd0, 13'd5));
        ld_word(8'd1, ins(3'd2, 13'd6));
        ld_word(8'd5, 16'h0003);
        ld_word(8'd6, 16'h0004);
        ld_acc(16'h0000);
        ld_pc(13'd0);
        rst = 1'b0;
        run_instrs(2, "lda_add");
        checks++;
        if (dp_acc !== 16'h0007) begin
            errors++;
            $display("FAIL lda_add_acc got %h want 0007", dp_acc);
        end
    endtask

    task automatic test_sta();
        enter_reset();
        ld_clear();
        ld_word(8'd0, ins(3'd1, 13'd9));
        ld_acc(16'h00AA);
        ld_pc(13'd0);
        rst = 1'b0;
        run_instrs(1, "sta");
        checks++;
        if (dp_mem[9] !== 16'h00AA) begin
            errors++;
            $display("FAIL sta_mem got %h want 00aa", dp_mem[9]);
        end
    endtask

    task automatic test_jz();
        for (int t = 0; t < 2; t++) begin
            enter_reset();
            ld_clear();
            ld_word(8'd16, ins(3'd7, 13'd20));
            ld_acc(16'(t));
            ld_pc(13'd16);
            rst = 1'b0;
            run_instrs(1, "jz");
            checks++;
            if (dp_pc !== ((t == 0) ? 13'd20 : 13'd17)) begin
                errors++;
                $display("FAIL jz_pc acc=%0d got %0d want %0d", t, dp_pc, (t == 0) ? 20 : 17);
            end
        end
    endtask

    task automatic test_back_to_back();
        enter_reset();
        ld_clear();
        ld_word(8'd0, ins(3'd5, 13'd0));
        ld_word(8'd1, ins(3'd6, 13'd0));
        ld_acc(16'hFFFE);
        ld_pc(13'd0);
        rst = 1'b0;
        run_instrs(6, "inc_jmp");
        checks++;
        if (dp_acc !== 16'h0001 || dp_pc !== 13'd0) begin
            errors++;
            $display("FAIL inc_jmp_final got acc=%h pc=%0d want 0001 0", dp_acc, dp_pc);
        end
    endtask

    task automatic test_reset_mid();
        // reset during MEM_RD of an LDA: acc must not change
        enter_reset();
        ld_clear();
        ld_word(8'd0, ins(3'd0, 13'd5));
        ld_word(8'd5, 16'h1234);
        ld_acc(16'h0055);
        ld_pc(13'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (bus.state !== 4'd2) begin
            errors++;
            $display("FAIL rmid_memrd state got %0d want 2", bus.state);
        end
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1;
            checks++;
            if (bus.state !== 4'd0 || bus.accWrite !== 1'b0) begin
                errors++;
                $display("FAIL rmid_memrd_after got st=%0d aw=%b want 0 0", bus.state, bus.accWrite);
            end
        end
        checks++;
        if (dp_acc !== 16'h0055) begin
            errors++;
            $display("FAIL rmid_memrd_acc got %h want 0055", dp_acc);
        end
        // reset during STORE: the location must keep its value
        @(negedge clk);
        ld_clear();
        ld_word(8'd0, ins(3'd1, 13'd9));
        ld_word(8'd9, 16'h1111);
        ld_acc(16'h2222);
        ld_pc(13'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (bus.state !== 4'd6 || bus.memWrite !== 1'b1) begin
            errors++;
            $display("FAIL rmid_store state got st=%0d mw=%b want 6 1", bus.state, bus.memWrite);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.memWrite !== 1'b0 || bus.instr_done !== 1'b0) begin
            errors++;
            $display("FAIL rmid_store_gate got mw=%b done=%b want 0 0", bus.memWrite, bus.instr_done);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.state !== 4'd0) begin
            errors++;
            $display("FAIL rmid_store_next got %0d want 0", bus.state);
        end
        checks++;
        if (dp_mem[9] !== 16'h1111) begin
            errors++;
            $display("FAIL rmid_store_mem got %h want 1111", dp_mem[9]);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            enter_reset();
            ld_clear();
            for (int a = 0; a < 64; a++)
                ld_word(8'(a), ins(3'($urandom_range(0, 7)), 13'($urandom_range(0, 63))));
            ld_acc(16'($urandom));
            ld_pc(13'($urandom_range(0, 63)));
            rst = 1'b0;
            run_instrs(40, "random");
            for (int a = 0; a < 64; a++) begin
                checks++;
                if (dp_mem[a] !== ref_mem[a]) begin
                    errors++;
                    $display("FAIL random_mem[%0d] got %h want %h", a, dp_mem[a], ref_mem[a]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lda_add();
        test_sta();
        test_jz();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
